// File: rtl/seq_match_recorder.sv
// seq_match_recorder: captures every sampled detector match as a
// {timestamp, gap} event in a small FIFO. A reader drains the FIFO with a
// valid/ready handshake. Saturating totals of matches and drops are kept.
module seq_match_recorder #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match,
  input  logic             clear,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_ts,
  output logic [TS_W-1:0]  ev_gap,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TS_W-1:0]  ts_reg;
  logic [TS_W-1:0]  gap_reg;
  logic [AW:0]      wptr_reg;
  logic [AW:0]      rptr_reg;
  logic [CNT_W-1:0] match_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic             push_req;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [TS_W-1:0]  gap_next;
  logic [TS_W-1:0]  slot_ts  [DEPTH];
  logic [TS_W-1:0]  slot_gap [DEPTH];

  // Occupancy flags come straight from the registered pointers; the extra
  // MSB distinguishes a wrapped (full) writer from an equal (empty) one.
  assign empty    = (wptr_reg == rptr_reg);
  assign full     = (wptr_reg[AW] != rptr_reg[AW]) &&
                    (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign ev_valid = ~empty;

  // A clear swallows any coincident match or pop. A pop on the same edge
  // frees a slot, so a full FIFO can still accept the push.
  assign push_req = match & ~clear;
  assign pop      = ev_valid & ev_ready & ~clear;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Gap counter: 1 right after a match, otherwise counts up and sticks at
  // all-ones, which also encodes "no previous match".
  always_comb begin
    gap_next = gap_reg;
    if (match)
      gap_next = TS_W'(1);
    else if (gap_reg != {TS_W{1'b1}})
      gap_next = gap_reg + TS_W'(1);
  end

  // Event storage: one register pair per slot, written at the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [TS_W-1:0] ts_slot_reg;
      logic [TS_W-1:0] gap_slot_reg;
      logic            wr_en;

      assign wr_en = push_ok && (wptr_reg[AW-1:0] == AW'(gi));

      // Slot contents: zeroed by reset so the idle head reads 0, else loaded on push.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ts_slot_reg  <= '0;
          gap_slot_reg <= '0;
        end else if (wr_en) begin
          ts_slot_reg  <= ts_reg;
          gap_slot_reg <= gap_reg;
        end
      end

      assign slot_ts[gi]  = ts_slot_reg;
      assign slot_gap[gi] = gap_slot_reg;
    end
  endgenerate

  // Head event is read straight from storage through the registered read pointer.
  assign ev_ts  = slot_ts[rptr_reg[AW-1:0]];
  assign ev_gap = slot_gap[rptr_reg[AW-1:0]];

  // Timestamp and gap trackers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg  <= '0;
      gap_reg <= '1;
    end else if (clear) begin
      ts_reg  <= '0;
      gap_reg <= '1;
    end else begin
      ts_reg  <= ts_reg + TS_W'(1);
      gap_reg <= gap_next;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (clear) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push_ok)
        wptr_reg <= wptr_reg + (AW+1)'(1);
      if (pop)
        rptr_reg <= rptr_reg + (AW+1)'(1);
    end
  end

  // Saturating match and drop totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else if (clear) begin
      match_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (push_req && (match_cnt_reg != {CNT_W{1'b1}}))
        match_cnt_reg <= match_cnt_reg + CNT_W'(1);
      if (drop && (drop_cnt_reg != {CNT_W{1'b1}}))
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end
  end

  assign match_count = match_cnt_reg;
  assign drop_count  = drop_cnt_reg;

endmodule

// File: tb/tb_seq_match_recorder.sv
// tb_seq_match_recorder: table-driven directed vectors for the match
// recorder, plus hand-written sequences for full+pop, single-entry
// push+pop, clear priority and asynchronous reset.
module tb_seq_match_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        match = 1'b0;
  logic        clear = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [15:0] ev_gap;
  logic [7:0]  match_count;
  logic [7:0]  drop_count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  seq_match_recorder #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .match(match), .clear(clear), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_ts(ev_ts), .ev_gap(ev_gap),
    .match_count(match_count), .drop_count(drop_count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m, c, r;
    logic        v;
    logic [15:0] t, g;
    logic [7:0]  mc, dc;
    logic        f, e;
  } vec_t;

  function automatic vec_t mk(logic m, logic c, logic r, logic v,
                              logic [15:0] t, logic [15:0] g,
                              logic [7:0] mc, logic [7:0] dc,
                              logic f, logic e);
    vec_t x;
    x.m = m; x.c = c; x.r = r; x.v = v; x.t = t; x.g = g;
    x.mc = mc; x.dc = dc; x.f = f; x.e = e;
    return x;
  endfunction

  // Compare all outputs; head fields only matter while an event is presented
  // (or when forced, for the post-reset zeros).
  task automatic chk(string nm, logic v, logic [15:0] t, logic [15:0] g,
                     logic [7:0] mc, logic [7:0] dc, logic f, logic e,
                     logic force_head);
    logic ok;
    ok = (ev_valid === v) && (match_count === mc) && (drop_count === dc) &&
         (full === f) && (empty === e);
    if (v || force_head)
      ok = ok && (ev_ts === t) && (ev_gap === g);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got v=%0b ts=%0d gap=%0d mc=%0d dc=%0d full=%0b empty=%0b, want v=%0b ts=%0d gap=%0d mc=%0d dc=%0d full=%0b empty=%0b",
               nm, ev_valid, ev_ts, ev_gap, match_count, drop_count, full, empty,
               v, t, g, mc, dc, f, e);
    end else begin
      $display("ok   %s: v=%0b ts=%0d gap=%0d mc=%0d dc=%0d full=%0b empty=%0b",
               nm, ev_valid, ev_ts, ev_gap, match_count, drop_count, full, empty);
    end
  endtask

  // Apply one edge with the given inputs, then sample 1 time unit later.
  task automatic step(logic m, logic c, logic r);
    match = m; clear = c; ev_ready = r;
    @(posedge clk);
    #1;
    match = 1'b0; clear = 1'b0; ev_ready = 1'b0;
  endtask

  vec_t tbl[25];

  initial begin
    // Edge index 0 is the first rising edge after rst is released.
    tbl[0]  = mk(0,0,0, 0,    0,      0, 0,0, 0,1);
    tbl[1]  = mk(0,0,0, 0,    0,      0, 0,0, 0,1);
    tbl[2]  = mk(0,0,0, 0,    0,      0, 0,0, 0,1);
    tbl[3]  = mk(1,0,0, 1,    3, 16'hFFFF, 1,0, 0,0);
    tbl[4]  = mk(0,0,0, 1,    3, 16'hFFFF, 1,0, 0,0);
    tbl[5]  = mk(1,0,0, 1,    3, 16'hFFFF, 2,0, 0,0);
    tbl[6]  = mk(0,0,1, 1,    5,      2, 2,0, 0,0);
    tbl[7]  = mk(0,0,1, 0,    0,      0, 2,0, 0,1);
    tbl[8]  = mk(0,0,0, 0,    0,      0, 2,0, 0,1);
    tbl[9]  = mk(0,0,0, 0,    0,      0, 2,0, 0,1);
    tbl[10] = mk(1,0,0, 1,   10,      5, 3,0, 0,0);
    tbl[11] = mk(1,0,0, 1,   10,      5, 4,0, 0,0);
    tbl[12] = mk(0,0,1, 1,   11,      1, 4,0, 0,0);
    tbl[13] = mk(0,0,1, 0,    0,      0, 4,0, 0,1);
    tbl[14] = mk(0,1,0, 0,    0,      0, 0,0, 0,1);
    tbl[15] = mk(1,0,0, 1,    0, 16'hFFFF, 1,0, 0,0);
    tbl[16] = mk(1,0,0, 1,    0, 16'hFFFF, 2,0, 0,0);
    tbl[17] = mk(1,0,0, 1,    0, 16'hFFFF, 3,0, 0,0);
    tbl[18] = mk(1,0,0, 1,    0, 16'hFFFF, 4,0, 1,0);
    tbl[19] = mk(1,0,0, 1,    0, 16'hFFFF, 5,1, 1,0);
    tbl[20] = mk(1,0,0, 1,    0, 16'hFFFF, 6,2, 1,0);
    tbl[21] = mk(0,0,1, 1,    1,      1, 6,2, 0,0);
    tbl[22] = mk(0,0,1, 1,    2,      1, 6,2, 0,0);
    tbl[23] = mk(0,0,1, 1,    3,      1, 6,2, 0,0);
    tbl[24] = mk(0,0,1, 0,    0,      0, 6,2, 0,1);

    // Reset state while rst is held.
    #3;
    chk("reset_hold", 0, 0, 0, 0, 0, 0, 1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].m, tbl[i].c, tbl[i].r);
      chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].t, tbl[i].g,
          tbl[i].mc, tbl[i].dc, tbl[i].f, tbl[i].e, 1'b0);
    end

    // Full FIFO with coincident push and pop: no drop, new event drains last.
    step(0,1,0);
    step(1,0,0); step(1,0,0); step(1,0,0); step(1,0,0);
    chk("fp_full", 1, 0, 16'hFFFF, 4, 0, 1, 0, 1'b0);
    step(1,0,1);
    chk("fp_pushpop", 1, 1, 1, 5, 0, 1, 0, 1'b0);
    step(0,0,1);
    chk("fp_drain1", 1, 2, 1, 5, 0, 0, 0, 1'b0);
    step(0,0,1);
    chk("fp_drain2", 1, 3, 1, 5, 0, 0, 0, 1'b0);
    step(0,0,1);
    chk("fp_drain3", 1, 4, 1, 5, 0, 0, 0, 1'b0);
    step(0,0,1);
    chk("fp_drain4", 0, 0, 0, 5, 0, 0, 1, 1'b0);

    // Single entry with coincident push and pop: valid stays high.
    step(0,1,0);
    step(1,0,0);
    chk("one_push", 1, 0, 16'hFFFF, 1, 0, 0, 0, 1'b0);
    step(1,0,1);
    chk("one_pushpop", 1, 1, 1, 2, 0, 0, 0, 1'b0);

    // Clear beats a coincident match.
    step(0,1,0);
    step(1,0,0); step(1,0,0);
    chk("clr_two", 1, 0, 16'hFFFF, 2, 0, 0, 0, 1'b0);
    step(1,1,0);
    chk("clr_prio", 0, 0, 0, 0, 0, 0, 1, 1'b0);
    step(0,0,0);
    step(1,0,0);
    chk("clr_next", 1, 1, 16'hFFFF, 1, 0, 0, 0, 1'b0);

    // Asynchronous reset mid-operation, checked before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", 0, 0, 0, 0, 0, 0, 1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    match = 1'b1;
    @(posedge clk);
    #1 match = 1'b0;
    chk("rst_after", 1, 0, 16'hFFFF, 1, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_match_recorder.md
# seq_match_recorder

Downstream consumer of the serial sequence detector's match pulse. Every cycle where `match` is high is captured as an event. Each event carries a free-running timestamp and the cycle gap since the previous match, and is buffered in a small FIFO. A downstream reader drains the FIFO through a valid/ready handshake, and the block also keeps saturating totals of matches and dropped events.

## Interface
- `TS_W`, 16: width of timestamp and gap fields.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the match and drop counters.

- `clk` in 1: rising-edge clock, shared with the detector.
- `rst` in 1: asynchronous, active-high reset.
- `match` in 1: detector output `z`, sampled every rising edge.
- `clear` in 1: synchronous clear of all state.
- `ev_ready` in 1: reader accepts the head event.
- `ev_valid` out 1: FIFO non-empty, head event presented.
- `ev_ts` out TS_W: timestamp of the head event.
- `ev_gap` out TS_W: gap field of the head event.
- `match_count` out CNT_W: matches seen, saturating.
- `drop_count` out CNT_W: matches lost to a full FIFO, saturating.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.

## Operation
- **`ts` register (TS_W):**
  - Reset value 0.
  - Increments by 1 every edge and wraps modulo 2^TS_W.
  - An event captures the pre-increment value.
- **`gap_cnt` register (TS_W):**
  - Reset value all-ones, meaning "no previous match".
  - On an edge with `match`: load 1.
  - Otherwise: increment, saturating at all-ones.
  - An event captures the pre-update value.
- **Push:** on an edge with `match=1`, `clear=0`, the event {ts, gap_cnt} is written at the write pointer.
  - If the FIFO is full and no pop happens on the same edge, the event is dropped and `drop_count` increments.
- **Pop:** on an edge with `ev_valid && ev_ready`, the read pointer advances. `ev_ready` while empty has no effect.
- **Simultaneous push and pop:**
  - When full: the push is accepted, occupancy stays DEPTH, and nothing is dropped.
  - When holding one entry: the old head pops, the new event becomes head, and `ev_valid` stays 1.
- **Pointers:** log2(DEPTH)+1 bits, with wrap handled by the extra MSB.
  - `full`/`empty` are derived from registered pointers.
- **`match_count`:** increments on every sampled match, dropped ones included. Saturates at all-ones.
- **`drop_count`:** saturates at all-ones.
- **`clear`:** has priority over `match` and pop on the same edge.
  - `ts`←0, `gap_cnt`←all-ones, FIFO emptied, both counters←0.
  - A coincident match is ignored and not counted.
- **Reset values:** `ev_valid`=0, `ev_ts`=0, `ev_gap`=0, `match_count`=0, `drop_count`=0, `full`=0, `empty`=1.
- **Idle outputs:** `ev_ts`/`ev_gap` are driven from the head slot. They are unchecked while `ev_valid`=0, except for the post-reset zeros.

## Timing
- **Capture latency:** a match sampled at edge k is visible as `ev_valid`=1 after edge k, i.e. in cycle k+1, when the FIFO was empty. There is no combinational bypass from `match`.
- **Drain rate:** one event per cycle while `ev_ready` is held high.
- **Output sourcing:**
  - `ev_valid`, `full` and `empty` are purely registered/pointer-derived; none depends combinationally on `ev_ready`.
  - `ev_ts`/`ev_gap` are the head-slot storage contents (combinational read of storage through the registered read pointer).
- **Reader rule:** the reader may hold `ev_ready` high continuously. `ev_valid` never drops without a pop, clear or reset.
- **Reset mid-operation:** `rst` asserted at any time immediately forces the reset values. The stored contents are discarded and are not recoverable.
- **Counter update:** both counters update on the same edge as the triggering match.

## Test plan
- **Basic capture:** `rst` released, then `match`=1 at edges 3 and 5, `ev_ready`=0. Required:
  - Events (ts=3, gap=65535) and (ts=5, gap=2).
  - `match_count`=2.
- **Back-to-back matches:** `match`=1 at edges 10 and 11. Required: second event has gap=1.
- **Overflow:** 6 matches with `ev_ready`=0 and DEPTH=4. Required:
  - `full`=1 after the 4th.
  - `drop_count`=2, `match_count`=6.
  - Draining yields the first four timestamps in order, then `empty`=1.
- **Full with simultaneous pop:** FIFO full, `match`=1 and `ev_ready`=1 on the same edge. Required:
  - `drop_count` unchanged and `full` still 1.
  - The new event is the last to drain.
- **Clear priority:** FIFO holding 2 events, `clear`=1 and `match`=1 together. Required:
  - Next cycle `empty`=1 and both counters 0.
  - The next match reports ts equal to the number of edges since the clear edge minus one, with gap=65535.
- **Reset mid-operation:** `rst` pulsed while `ev_valid`=1. Required: all outputs return to the reset values without waiting for a clock edge.
